// File: rtl/code_sender_pkg.sv
// -----------------------------------------------------------------------------
// code_sender_pkg
//   Shared definitions for the serial code sender:
//     - default values for the code width and the per-bit hold time
//     - width of the per-bit cycle timer (BIT_CYCLES is at most 255)
//     - frame length, which depends on whether the parity bit is appended
//     - FSM state encoding
//   Optional feature macro: CODE_SENDER_PARITY_EN (appends an even-parity bit).
// -----------------------------------------------------------------------------
package code_sender_pkg;

  localparam int unsigned CODE_W_DEFAULT     = 8;
  localparam int unsigned BIT_CYCLES_DEFAULT = 4;

  // Wide enough for any legal BIT_CYCLES value (1..255).
  localparam int unsigned TIMER_W = 8;

`ifdef CODE_SENDER_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
`else
  localparam int unsigned PARITY_BITS = 0;
`endif

  // Number of bit periods in one frame for a given code width.
  function automatic int unsigned frame_bits(input int unsigned code_w);
    return code_w + PARITY_BITS;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
`ifdef CODE_SENDER_PARITY_EN
    PAR  = 2'd2,
`endif
    FIN  = 2'd3
  } state_t;

endpackage : code_sender_pkg

// File: rtl/code_sender_if.sv
// -----------------------------------------------------------------------------
// code_sender_if
//   Request/serial-output bundle of the code sender.
//     start    : single-cycle send request            (master -> slave)
//     code     : code word, sampled on accepted start (master -> slave)
//     out_data : serial bit, MSB first                (slave -> master)
//     out_en   : one strobe per bit period            (slave -> master)
//     busy     : transmission in progress             (slave -> master)
//     done     : one-cycle pulse after the last bit   (slave -> master)
//   Modports: master (requester / bench), slave (code_sender).
// -----------------------------------------------------------------------------
interface code_sender_if
  import code_sender_pkg::*;
#(
  parameter int unsigned CODE_W = CODE_W_DEFAULT
);

  logic              start;
  logic [CODE_W-1:0] code;
  logic              out_data;
  logic              out_en;
  logic              busy;
  logic              done;

  modport master (
    output start,
    output code,
    input  out_data,
    input  out_en,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  code,
    output out_data,
    output out_en,
    output busy,
    output done
  );

endinterface : code_sender_if

// File: rtl/code_sender_bit_timer.sv
// -----------------------------------------------------------------------------
// bit_timer
//   Free-running modulo-CYCLES counter that paces one bit period.
//   Ports:
//     clk     : clock, rising edge
//     rst_n   : asynchronous active-low reset (counter to 0)
//     clr_i   : synchronous clear (counter to 0), wins over en_i
//     en_i    : advance the counter this cycle
//     first_o : counter is in the first cycle of a bit period
//     last_o  : counter is in the last cycle of a bit period
//   The counter wraps to 0 on its own after the last cycle, so consecutive bit
//   periods need no extra clear. With CYCLES=1 both flags are always high.
// -----------------------------------------------------------------------------
module bit_timer
  import code_sender_pkg::*;
#(
  parameter int unsigned CYCLES = BIT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic first_o,
  output logic last_o
);

  localparam logic [TIMER_W-1:0] LAST_CNT = TIMER_W'(CYCLES - 1);

  logic [TIMER_W-1:0] cnt_q;
  logic [TIMER_W-1:0] cnt_d;

  assign first_o = (cnt_q == '0);
  assign last_o  = (cnt_q == LAST_CNT);

  // NOTE: every variable assigned in always_comb gets a default on entry;
  // a path that leaves it unassigned would infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = last_o ? '0 : cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : bit_timer

// File: rtl/code_sender.sv
// -----------------------------------------------------------------------------
// code_sender
//   Serialises a CODE_W-bit code word MSB first, holding each bit on out_data
//   for BIT_CYCLES clocks and marking the first cycle of every bit period with
//   an out_en strobe. A one-cycle done pulse follows the last bit period.
//   Ports:
//     clk   : clock, rising edge
//     clr_n : asynchronous active-low reset
//     bus   : code_sender_if.slave (start, code, out_data, out_en, busy, done)
//   Parameters:
//     CODE_W     : code width in bits
//     BIT_CYCLES : clocks per bit, legal range 1..255
//   Optional feature macro: CODE_SENDER_PARITY_EN -- appends one even-parity
//   bit (XOR of the captured code) as an extra bit period in state PAR.
//   Without the macro there is no PAR state and no parity logic.
// -----------------------------------------------------------------------------
module code_sender
  import code_sender_pkg::*;
#(
  parameter int unsigned CODE_W     = CODE_W_DEFAULT,
  parameter int unsigned BIT_CYCLES = BIT_CYCLES_DEFAULT
) (
  input  logic         clk,
  input  logic         clr_n,
  code_sender_if.slave bus
);

  localparam int unsigned FRAME_BITS = frame_bits(CODE_W);
  localparam int unsigned BIT_CNT_W  = $clog2(FRAME_BITS + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = BIT_CNT_W'(CODE_W - 1);

  state_t               state_q;
  logic [CODE_W-1:0]    shift_q;
  logic [CODE_W-1:0]    shift_nxt;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic                 out_data_q;
  logic                 busy_q;
  logic                 done_q;
`ifdef CODE_SENDER_PARITY_EN
  logic                 par_q;
`endif

  logic accept;
  logic bit_first;
  logic bit_last;

  // start is only honoured in IDLE: it is ignored while busy and during FIN.
  assign accept    = (state_q == IDLE) && bus.start;
  assign shift_nxt = shift_q << 1;

  // The timer runs exactly while a bit period is on the line (SEND/PAR) and is
  // cleared on acceptance, so the first SEND cycle is always a first cycle.
  bit_timer #(
    .CYCLES (BIT_CYCLES)
  ) u_bit_timer (
    .clk     (clk),
    .rst_n   (clr_n),
    .clr_i   (accept),
    .en_i    (busy_q),
    .first_o (bit_first),
    .last_o  (bit_last)
  );

  // out_en is a decode of registered state only, so it drops with busy on
  // reset and stays low in IDLE and FIN.
  assign bus.out_data = out_data_q;
  assign bus.out_en   = busy_q & bit_first;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      // NOTE: the shift register is cleared by reset as well, so no stale code
      // bits survive an aborted frame.
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      out_data_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef CODE_SENDER_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q    <= SEND;
            shift_q    <= bus.code;
            bit_cnt_q  <= '0;
            out_data_q <= bus.code[CODE_W-1];
            busy_q     <= 1'b1;
`ifdef CODE_SENDER_PARITY_EN
            par_q      <= ^bus.code;
`endif
          end
        end

        SEND: begin
          if (bit_last) begin
            shift_q   <= shift_nxt;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_DATA_BIT) begin
`ifdef CODE_SENDER_PARITY_EN
              state_q    <= PAR;
              out_data_q <= par_q;
`else
              state_q    <= FIN;
              out_data_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
`endif
            end else begin
              // out_data tracks the MSB of the shift register after the shift.
              out_data_q <= shift_nxt[CODE_W-1];
            end
          end
        end

`ifdef CODE_SENDER_PARITY_EN
        PAR: begin
          if (bit_last) begin
            state_q    <= FIN;
            bit_cnt_q  <= bit_cnt_q + 1'b1;
            out_data_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end
        end
`endif

        FIN: begin
          state_q <= IDLE;
        end

        default: begin
          state_q    <= IDLE;
          out_data_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  // Output consistency: a strobe only inside a transmission, and the done
  // cycle carries no data.
  a_en_implies_busy : assert property (
    @(posedge clk) disable iff (!clr_n) bus.out_en |-> bus.busy
  );
  a_done_quiet : assert property (
    @(posedge clk) disable iff (!clr_n)
      bus.done |-> (!bus.busy && !bus.out_en && !bus.out_data)
  );

endmodule : code_sender

// File: tb/tb_code_sender.sv
// -----------------------------------------------------------------------------
// tb_code_sender
//   Two code_sender instances (BIT_CYCLES=4 and BIT_CYCLES=1) driven with
//   directed and random requests. Expected outputs come from a frame-level
//   model: after an accepted start, cycle k of the frame (k=1..NB*B) carries
//   frame bit (k-1)/B with a strobe when (k-1)%B==0, and cycle NB*B+1 is the
//   done cycle. A bench-side lock receiver latches out_data on out_en.
//   Honours CODE_SENDER_PARITY_EN for the expected frame length.
// -----------------------------------------------------------------------------
module tb_code_sender;

  localparam int W  = 8;
  localparam int B0 = 4;
  localparam int B1 = 1;
`ifdef CODE_SENDER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic clk   = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  code_sender_if #(.CODE_W(W)) if0 ();
  code_sender_if #(.CODE_W(W)) if1 ();

  code_sender #(.CODE_W(W), .BIT_CYCLES(B0)) u_dut0 (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (if0.slave)
  );

  code_sender #(.CODE_W(W), .BIT_CYCLES(B1)) u_dut1 (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (if1.slave)
  );

  // Lock receivers: unlock output follows each strobed bit.
  logic rx0, rx1;
  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) rx0 <= 1'b0;
    else if (if0.out_en) rx0 <= if0.out_data;
  end
  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) rx1 <= 1'b0;
    else if (if1.out_en) rx1 <= if1.out_data;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int             bc     [2] = '{B0, B1};
  bit             act_m  [2];
  int             k_m    [2];
  logic [W-1:0]   code_m [2];
  logic           start_v[2];
  logic [W-1:0]   code_v [2];

  function automatic logic frame_bit(input logic [W-1:0] c, input int i);
    if (i < W) return c[W-1-i];
    return ^c;  // even parity: makes the total count of ones even
  endfunction

  // {busy, done, out_en, out_data}
  function automatic logic [3:0] exp_outs(input int i);
    if (!act_m[i]) return 4'b0000;
    if (k_m[i] <= NB * bc[i])
      return {1'b1, 1'b0, ((k_m[i] - 1) % bc[i] == 0),
              frame_bit(code_m[i], (k_m[i] - 1) / bc[i])};
    return 4'b0100;
  endfunction

  function automatic logic [3:0] got_outs(input int i);
    if (i == 0) return {if0.busy, if0.done, if0.out_en, if0.out_data};
    return {if1.busy, if1.done, if1.out_en, if1.out_data};
  endfunction

  function automatic logic rx_got(input int i);
    return (i == 0) ? rx0 : rx1;
  endfunction

  // One clock: check this cycle, drive next inputs, advance model over the edge.
  task automatic step();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("outs%0d", i), 32'(got_outs(i)), 32'(exp_outs(i)));
      if (act_m[i] && k_m[i] >= 2)
        check($sformatf("rx%0d", i), 32'(rx_got(i)),
              32'(frame_bit(code_m[i], (k_m[i] - 2) / bc[i])));
    end
    if0.start = start_v[0];
    if0.code  = code_v[0];
    if1.start = start_v[1];
    if1.code  = code_v[1];
    for (int i = 0; i < 2; i++) begin
      if (act_m[i]) begin
        k_m[i]++;
        if (k_m[i] > NB * bc[i] + 1) act_m[i] = 1'b0;
      end else if (start_v[i]) begin
        act_m[i]  = 1'b1;
        k_m[i]    = 1;
        code_m[i] = code_v[i];
      end
    end
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    code_v[0]  = W'($urandom);
    code_v[1]  = W'($urandom);
  endtask

  // Mid-cycle asynchronous reset on both instances.
  task automatic async_reset();
    #2 clr_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("async_rst%0d", i), 32'(got_outs(i)), 32'h0);
      act_m[i] = 1'b0;
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      check($sformatf("in_rst%0d", i), 32'(got_outs(i)), 32'h0);
    clr_n = 1'b1;
  endtask

  // Send one frame on instance 0 and check strobe count, done timing, receiver.
  task automatic send_and_watch(input string tag, input logic [W-1:0] c, input bit retrigger);
    int ns   = 0;
    int dcyc = -1;
    start_v[0] = 1'b1;
    code_v[0]  = c;
    step();
    for (int cyc = 1; cyc <= NB * B0 + 4; cyc++) begin
      if (if0.out_en) ns++;
      if (if0.done && dcyc < 0) dcyc = cyc;
      if (retrigger && (cyc == 10 || cyc == NB * B0 + 1)) begin
        start_v[0] = 1'b1;
        code_v[0]  = ~c;
      end
      step();
    end
    check({tag, "_strobes"}, ns, NB);
    check({tag, "_done_cyc"}, dcyc, NB * B0 + 1);
    check({tag, "_rx_final"}, 32'(rx0), 32'(frame_bit(c, NB - 1)));
  endtask

  initial begin
    int n_ones;
    int n_en;
    for (int i = 0; i < 2; i++) begin
      act_m[i]   = 1'b0;
      k_m[i]     = 0;
      code_m[i]  = '0;
      start_v[i] = 1'b0;
      code_v[i]  = '0;
    end
    if0.start = 1'b0; if0.code = '0;
    if1.start = 1'b0; if1.code = '0;

    repeat (2) @(negedge clk);
    check("reset0", 32'(got_outs(0)), 32'h0);
    check("reset1", 32'(got_outs(1)), 32'h0);
    clr_n = 1'b1;
    step();
    step();

    send_and_watch("a5", 8'hA5, 1'b0);
    send_and_watch("07", 8'h07, 1'b0);
    send_and_watch("retrig", 8'h3C, 1'b1);

    // Abort at cycle 12, then a full frame straight after release.
    start_v[0] = 1'b1;
    code_v[0]  = 8'h96;
    step();
    for (int c = 1; c < 12; c++) step();
    async_reset();
    send_and_watch("after_rst", 8'h5A, 1'b0);

    // BIT_CYCLES=1 with all ones.
    start_v[1] = 1'b1;
    code_v[1]  = 8'hFF;
    step();
    n_ones = 0;
    n_en   = 0;
    for (int c = 1; c <= NB + 3; c++) begin
      if (if1.out_en) n_en++;
      if (if1.out_en && if1.out_data) n_ones++;
      step();
    end
    check("ff_strobes", n_en, NB);
    check("ff_ones", n_ones, W);
    check("ff_rx_final", 32'(rx1), 32'(frame_bit(8'hFF, NB - 1)));

    // Random requests on both instances, many landing while busy.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 5) == 0) begin
          start_v[i] = 1'b1;
          code_v[i]  = W'($urandom);
        end
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_code_sender

// File: doc/code_sender.md
CODE_SENDER -- requirements
Module: code_sender

Interface
REQ-001 Parameter CODE_W, default 8: code width in bits.
REQ-002 Parameter BIT_CYCLES, default 4: clock cycles each bit is held on out_data; legal range 1..255.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port clr_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: single-cycle request to send code.
REQ-006 The block SHALL have port code, input, CODE_W bits: code word, sampled only on an accepted start.
REQ-007 The block SHALL have port out_data, output, 1 bit: serial code bit, MSB first.
REQ-008 The block SHALL have port out_en, output, 1 bit: one-cycle strobe marking out_data valid, for direct connection to a lock receiver's data/enable pair.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a transmission is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse after the final bit period.

Function
REQ-011 The FSM SHALL have states IDLE, SEND, PAR (macro builds only) and FIN.
REQ-012 IDLE with start=1 SHALL capture code into a shift register, clear the bit counter and cycle timer, and enter SEND at the next edge.
REQ-013 In SEND, out_data SHALL equal the current shift-register MSB for exactly BIT_CYCLES cycles per bit.
REQ-014 out_en SHALL be high only in the first cycle of each bit period, giving exactly one strobe per bit.
REQ-015 At the end of each bit period the register SHALL shift left by one with zero fill, and the bit counter SHALL increment.
REQ-016 After bit CODE_W-1 completes, the FSM SHALL enter PAR if the macro is defined, otherwise FIN.
REQ-017 FIN SHALL last one cycle with done=1, out_en=0 and out_data=0, then return to IDLE.
REQ-018 busy SHALL be 1 in SEND and PAR and 0 in IDLE and FIN.
REQ-019 start SHALL be ignored while busy=1 and during FIN; there is no queuing.
REQ-020 Changes on code after acceptance SHALL NOT affect the word in flight.
REQ-021 Latency from the start cycle to the first out_en SHALL be exactly 1 clock.
REQ-022 Total transmission SHALL take (CODE_W [+1 if parity]) * BIT_CYCLES cycles, followed by the done cycle.
REQ-023 With BIT_CYCLES=1, out_en SHALL be high on every cycle of SEND and PAR.
REQ-024 In IDLE, out_data SHALL be 0 and out_en SHALL be 0.

Reset
REQ-025 clr_n=0 SHALL immediately force IDLE and set out_data=0, out_en=0, busy=0, done=0, the shift register to 0 and all counters to 0, independent of clk.
REQ-026 Reset asserted mid-transmission SHALL abort it with no done pulse; the first rising clk edge after clr_n rises SHALL see IDLE.

Configuration
REQ-027 Macro CODE_SENDER_PARITY_EN defined: the block SHALL append one even-parity bit (XOR of the captured code) in state PAR, held BIT_CYCLES cycles with one out_en strobe.
REQ-028 CODE_SENDER_PARITY_EN undefined: the block SHALL have no PAR state and no parity logic, and SHALL send exactly CODE_W bits.

Structure
REQ-029 Package code_sender_pkg SHALL hold the state encoding typedef, the default values for CODE_W and BIT_CYCLES, and the parity-enable-dependent frame-length constant.
REQ-030 The cycle timer SHALL be implemented in sub-module bit_timer: a counter that outputs a first-cycle flag and a last-cycle flag, with synchronous clear and async active-low reset.

Verification
REQ-031 Reset, then start with code=8'hA5, BIT_CYCLES=4, no macro -> out_en strobes at cycles 1,5,...,29; out_data sequence 1,0,1,0,0,1,0,1; done at cycle 33.
REQ-032 Macro defined, code=8'h07 -> nine strobes; ninth bit =1 (odd count of ones); done after 36 bit cycles.
REQ-033 start pulsed again at cycle 10 and in the done cycle with different code -> ignored; the original frame completes unchanged; busy never deasserts early.
REQ-034 clr_n low at cycle 12 -> all outputs 0 asynchronously with no done pulse; a new start after release sends the full frame correctly.
REQ-035 BIT_CYCLES=1, code=8'hFF -> out_en high 8 consecutive cycles; out_data=1 throughout.
REQ-036 Chain to the lock receiver (out_data->in_data, out_en->in_en) -> the receiver's unlock output follows each strobed bit; final value equals the code LSB, or the parity bit in macro builds.
